line_event_encoder: RTL and testbench

- Reverse of the team's 3-to-8 line decoder: takes 8 raw one-hot-style input lines (switches or buttons) and turns them into 3-bit event codes.
- Each line is synchronised and debounced. Each debounced rising edge is latched as a pending event.
- Pending events are priority-arbitrated and presented one at a time on a valid/ready output port.
- Sits between the board switch bank and the display/control logic, which consumes the codes.

---
 rtl/line_enc_pkg.sv | 18 +
 rtl/line_debounce.sv | 52 +++++
 rtl/line_event_encoder.sv | 146 ++++++++++++++
 tb/tb_line_event_encoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/line_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : line_enc_pkg
// Purpose  : Shared constants and FSM state type for the line event encoder.
// Revision : 1.0 - initial release
// ============================================================================
package line_enc_pkg;

  localparam int N_LINES = 8;
  localparam int CODE_W  = $clog2(N_LINES);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } enc_state_t;

endpackage
`default_nettype wire

// File: rtl/line_debounce.sv
`default_nettype none
// ============================================================================
// Module   : line_debounce
// Purpose  : One input line: 2-flop synchroniser, stability counter and
//            debounced level register with a same-cycle rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module line_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level_out,
  output logic rise_out
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_level;
  logic [7:0] r_cnt;
  logic       w_flip;

  // The counter holds DEB_CYCLES-1 differing samples; the next differing
  // sample is the one that would reach DEB_CYCLES, so the level flips now.
  assign w_flip    = (r_sync2 != r_level) && (r_cnt == 8'(DEB_CYCLES - 1));
  assign rise_out  = w_flip && !r_level;
  assign level_out = r_level;

  // Synchronise the raw line, then count consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= 8'd0;
      end else if (w_flip) begin
        r_cnt   <= 8'd0;
        r_level <= ~r_level;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/line_event_encoder.sv
`default_nettype none
// ============================================================================
// Module   : line_event_encoder
// Purpose  : Debounces 8 raw lines, latches each debounced rising edge as a
//            pending event and presents the events one at a time as 3-bit
//            codes on a valid/ready port. Lost events set a sticky overflow.
//            Build option ROUND_ROBIN_EN selects round-robin arbitration
//            instead of fixed lowest-index priority.
// Revision : 1.0 - initial release
// ============================================================================
module line_event_encoder
  import line_enc_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LINES-1:0] lines_in,
  output logic [CODE_W-1:0]  code_out,
  output logic               valid_out,
  input  logic               ready_in,
  output logic [N_LINES-1:0] active_out,
  output logic               overflow_out
);

  logic [N_LINES-1:0] w_level;
  logic [N_LINES-1:0] w_rise;
  logic [N_LINES-1:0] r_pend;
  logic [N_LINES-1:0] w_clr;
  logic [CODE_W-1:0]  w_win;
  logic               w_any;
  logic               w_load;
  logic [CODE_W-1:0]  r_code;
  logic               r_valid;
  logic               r_overflow;
  enc_state_t         r_state;

  generate
    for (genvar i = 0; i < N_LINES; i++) begin : g_line
      line_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
      ) u_deb (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (lines_in[i]),
        .level_out (w_level[i]),
        .rise_out  (w_rise[i])
      );
    end
  endgenerate

  assign w_any = |r_pend;

`ifdef ROUND_ROBIN_EN
  logic [CODE_W-1:0] r_ptr;
  logic              w_found;

  // Search from the pointer upwards; 3-bit addition wraps 7 back to 0.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N_LINES; k++) begin
      if (!w_found && r_pend[r_ptr + CODE_W'(k)]) begin
        w_win   = r_ptr + CODE_W'(k);
        w_found = 1'b1;
      end
    end
  end

  // Pointer moves just past the line granted on every load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_load) begin
      r_ptr <= w_win + CODE_W'(1);
    end
  end
`else
  // Fixed priority: scanning downwards leaves the lowest set index.
  always_comb begin
    w_win = '0;
    for (int k = N_LINES - 1; k >= 0; k--) begin
      if (r_pend[k]) begin
        w_win = CODE_W'(k);
      end
    end
  end
`endif

  // A load happens from IDLE, or from PRESENT when the current code is taken.
  assign w_load = w_any && ((r_state == IDLE) || ready_in);
  assign w_clr  = w_load ? (N_LINES'(1) << w_win) : '0;

  // Pending set/clear; a rise on a line being loaded this cycle is a new event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_rise;
      if (|(w_rise & r_pend & ~w_clr)) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Presentation FSM with registered code/valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_code  <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_code  <= w_win;
            r_valid <= 1'b1;
            r_state <= PRESENT;
          end
        end
        PRESENT: begin
          if (ready_in) begin
            if (w_load) begin
              r_code <= w_win;
            end else begin
              r_valid <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign code_out     = r_code;
  assign valid_out    = r_valid;
  assign active_out   = w_level;
  assign overflow_out = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_line_event_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_event_encoder
// Purpose  : Directed self-checking bench for line_event_encoder with a
//            scoreboard of expected codes consumed on each accepted transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_event_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] lines_in;
  logic [2:0] code_out;
  logic       valid_out;
  logic       ready_in;
  logic [7:0] active_out;
  logic       overflow_out;

  int vectors    = 0;
  int miscompares = 0;
  logic [2:0] exp_q[$];

`ifdef ROUND_ROBIN_EN
  int unsigned rr_ptr = 0;
`endif

  line_event_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .lines_in     (lines_in),
    .code_out     (code_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .active_out   (active_out),
    .overflow_out (overflow_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Expected delivery order for events that all become pending together.
  task automatic push_mask(input logic [7:0] m);
`ifdef ROUND_ROBIN_EN
    for (int k = 0; k < 8; k++) begin
      int unsigned idx;
      idx = (rr_ptr + k) % 8;
      if (m[idx]) exp_q.push_back(3'(idx));
    end
    for (int k = 7; k >= 0; k--) begin
      int unsigned idx;
      idx = (rr_ptr + k) % 8;
      if (m[idx]) begin
        rr_ptr = (idx + 1) % 8;
        break;
      end
    end
`else
    for (int k = 0; k < 8; k++) begin
      if (m[k]) exp_q.push_back(3'(k));
    end
`endif
  endtask

  // Scoreboard: an accepted transfer pops and compares the oldest expectation.
  always @(negedge clk) begin
    if (!rst && valid_out && ready_in) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL spurious_transfer: observed code %0d expected no transfer", code_out);
      end else begin
        check("scoreboard_code", {29'b0, code_out}, {29'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst      = 1'b1;
    lines_in = 8'hFF;
    ready_in = 1'b1;

    // Reset held with all lines high: nothing may leak out.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_valid", {31'b0, valid_out}, 32'd0);
      check("rst_active", {24'b0, active_out}, 32'd0);
      check("rst_overflow", {31'b0, overflow_out}, 32'd0);
    end
    rst = 1'b0;
    push_mask(8'hFF);
    ticks(6);
    check("post_rst_early", {31'b0, valid_out}, 32'd0);
    tick();
    check("post_rst_valid", {31'b0, valid_out}, 32'd1);
    check("post_rst_code", {29'b0, code_out}, 32'd0);
    ticks(8);
    check("post_rst_drain", {31'b0, valid_out}, 32'd0);
    lines_in = 8'h00;
    ticks(10);
    check("release_active", {24'b0, active_out}, 32'd0);

    // Single press on line 5.
    lines_in = 8'h20;
    push_mask(8'h20);
    ticks(6);
    check("single_early", {31'b0, valid_out}, 32'd0);
    tick();
    check("single_valid", {31'b0, valid_out}, 32'd1);
    check("single_code", {29'b0, code_out}, 32'd5);
    check("single_active", {24'b0, active_out}, 32'h20);
    tick();
    check("single_one_cycle", {31'b0, valid_out}, 32'd0);
    lines_in = 8'h00;
    ticks(10);

    // Glitch of 3 cycles on line 2.
    lines_in = 8'h04;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) lines_in = 8'h00;
      tick();
      check("glitch_valid", {31'b0, valid_out}, 32'd0);
      check("glitch_active", {24'b0, active_out}, 32'd0);
    end

    // Lines 6, 1, 3 together: three back-to-back codes.
    lines_in = 8'h4A;
    push_mask(8'h4A);
    ticks(7);
    check("simul_valid0", {31'b0, valid_out}, 32'd1);
    tick();
    check("simul_valid1", {31'b0, valid_out}, 32'd1);
    tick();
    check("simul_valid2", {31'b0, valid_out}, 32'd1);
    tick();
    check("simul_done", {31'b0, valid_out}, 32'd0);
    lines_in = 8'h00;
    ticks(10);

    // Backpressure on line 4, with line 0 pressed while stalled.
    ready_in = 1'b0;
    lines_in = 8'h10;
    push_mask(8'h10);
    ticks(7);
    for (int i = 0; i < 20; i++) begin
      if (i == 2) lines_in = 8'h11;
      tick();
      check("bp_valid", {31'b0, valid_out}, 32'd1);
      check("bp_code", {29'b0, code_out}, 32'd4);
    end
    push_mask(8'h01);
    ready_in = 1'b1;
    tick();
    check("bp_next_valid", {31'b0, valid_out}, 32'd1);
    check("bp_next_code", {29'b0, code_out}, 32'd0);
    tick();
    check("bp_done", {31'b0, valid_out}, 32'd0);
    lines_in = 8'h00;
    ticks(10);

    // Overflow: line 7 presented, then pressed twice more while stalled.
    ready_in = 1'b0;
    lines_in = 8'h80;
    push_mask(8'h80);
    ticks(7);
    check("ovf_present", {29'b0, code_out}, 32'd7);
    lines_in = 8'h00;
    ticks(8);
    lines_in = 8'h80;
    push_mask(8'h80);
    ticks(8);
    check("ovf_not_yet", {31'b0, overflow_out}, 32'd0);
    lines_in = 8'h00;
    ticks(8);
    lines_in = 8'h80;
    ticks(8);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ovf_sticky", {31'b0, overflow_out}, 32'd1);
      check("ovf_hold_code", {29'b0, code_out}, 32'd7);
    end
    ready_in = 1'b1;
    tick();
    check("ovf_second7_valid", {31'b0, valid_out}, 32'd1);
    check("ovf_second7_code", {29'b0, code_out}, 32'd7);
    tick();
    check("ovf_only_one", {31'b0, valid_out}, 32'd0);
    check("ovf_still_set", {31'b0, overflow_out}, 32'd1);
    lines_in = 8'h00;
    ticks(10);

    // Reset while a code is presented and unaccepted.
    ready_in = 1'b0;
    lines_in = 8'h08;
    ticks(7);
    check("midrst_present", {29'b0, code_out}, 32'd3);
    rst = 1'b1;
    tick();
    check("midrst_valid", {31'b0, valid_out}, 32'd0);
    check("midrst_overflow", {31'b0, overflow_out}, 32'd0);
    check("midrst_active", {24'b0, active_out}, 32'd0);
    rst      = 1'b0;
    lines_in = 8'h00;
    tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
